// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
    typedef enum logic {RUN, MC_BUSY} hz_state_t;
    localparam logic [31:0] NOP_INST = 32'h00000013;
    localparam int DEF_REG_W = 5;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs
//   master: pipeline side (drives ID/EX status, receives enables/flushes)
//   slave:  hazard controller (reads status, drives enables/flushes)
interface pipe_hazard_ctrl_if import pipe_ctrl_pkg::*; #(parameter int REG_W = DEF_REG_W);
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs2;
    logic             id_is_mc;
    logic             ex_memRead;
    logic [REG_W-1:0] ex_rd;
    logic             branch_taken;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             Flush_HD;
    logic             ex_hold;
    logic             mem_bubble;
    logic             busy_o;
    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, id_is_mc, ex_memRead, ex_rd, branch_taken,
        input  pcWrite, ifidWrite, ifidFlush, Flush_HD, ex_hold, mem_bubble, busy_o
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_is_mc, ex_memRead, ex_rd, branch_taken,
        output pcWrite, ifidWrite, ifidFlush, Flush_HD, ex_hold, mem_bubble, busy_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load in EX
//   in:  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_memRead, ex_rd
//   out: lu (load-use hazard this cycle)
module load_use_detect import pipe_ctrl_pkg::*; #(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_rd,
    output logic             lu
);
    // x0 is hardwired zero, so a load to it never creates a dependency
    assign lu = id_valid && ex_memRead && (ex_rd != '0) &&
                ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch squash and multi-cycle EX hold scheduler
//   clk, rst: falling-edge clock, async active-high reset
//   hz (slave): ID/EX status in; PC/IF-ID/ID-EX/EX-MEM enables and flushes out
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
    parameter int MC_LAT = 4,
    parameter int REG_W  = DEF_REG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    pipe_hazard_ctrl_if.slave        hz
);
    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);
    hz_state_t  state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       lu, busy, mc_start;
    load_use_detect #(.REG_W(REG_W)) u_lu (
        .id_valid    (hz.id_valid),
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_uses_rs2 (hz.id_uses_rs2),
        .ex_memRead  (hz.ex_memRead),
        .ex_rd       (hz.ex_rd),
        .lu          (lu)
    );
    assign busy     = (state == MC_BUSY);
    // ID/EX only latches the mc op when it is neither stalled nor squashed
    assign mc_start = hz.id_valid && hz.id_is_mc && !lu && !hz.branch_taken && (MC_LAT > 1);
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // cnt==1 leaves after MC_LAT-1 busy cycles; the op's last EX cycle runs in RUN
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!busy && mc_start) begin
            state_nx = MC_BUSY;
            cnt_nx   = MC_LOAD;
        end else if (busy) begin
            cnt_nx   = cnt - 4'd1;
            state_nx = (cnt == 4'd1) ? RUN : MC_BUSY;
        end
    end
    // branch squash outranks load-use stall; rst forces a safe bubble regardless of state
    always_comb begin
        hz.pcWrite    = !rst && !busy && (hz.branch_taken || !lu);
        hz.ifidWrite  = !rst && !busy && (hz.branch_taken || !lu);
        hz.ifidFlush  = rst || (!busy && hz.branch_taken);
        hz.Flush_HD   = rst || (!busy && (hz.branch_taken || lu));
        hz.ex_hold    = !rst && busy;
        hz.mem_bubble = rst || busy;
        hz.busy_o     = !rst && busy;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random check of two controllers (MC_LAT 4 and 1) against a cycle model
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   left4 = 0;
    int   left1 = 0;
    logic       v, u2, mc, mr, bt;
    logic [4:0] rs1, rs2, rd;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(5)) h4 ();
    pipe_hazard_ctrl_if #(.REG_W(5)) h1 ();
    pipe_hazard_ctrl #(.MC_LAT(4), .REG_W(5)) dut4 (.clk(clk), .rst(rst), .hz(h4.slave));
    pipe_hazard_ctrl #(.MC_LAT(1), .REG_W(5)) dut1 (.clk(clk), .rst(rst), .hz(h1.slave));

    // {pcWrite, ifidWrite, ifidFlush, Flush_HD, ex_hold, mem_bubble, busy_o}
    function automatic logic [6:0] expect_out(input int left);
        logic hazard;
        hazard = v && mr && (rd != 0) && (rs1 == rd || (u2 && rs2 == rd));
        if (rst)       return 7'b0011010;
        if (left > 0)  return 7'b0000111;
        if (bt)        return 7'b1111000;
        if (hazard)    return 7'b0001000;
        return 7'b1100000;
    endfunction

    function automatic int next_left(input int left, input int lat);
        logic hazard;
        hazard = v && mr && (rd != 0) && (rs1 == rd || (u2 && rs2 == rd));
        if (rst)      return 0;
        if (left > 0) return left - 1;
        if (v && mc && !hazard && !bt && lat > 1) return lat - 1;
        return 0;
    endfunction

    task automatic drive(input logic r, input logic iv, input logic [4:0] a, input logic [4:0] b,
                         input logic ub, input logic m, input logic ld, input logic [4:0] d,
                         input logic br, input string tag);
        logic [6:0] o4, o1, e4, e1;
        @(posedge clk);
        rst = r; v = iv; rs1 = a; rs2 = b; u2 = ub; mc = m; mr = ld; rd = d; bt = br;
        h4.id_valid = iv; h4.id_rs1 = a; h4.id_rs2 = b; h4.id_uses_rs2 = ub;
        h4.id_is_mc = m; h4.ex_memRead = ld; h4.ex_rd = d; h4.branch_taken = br;
        h1.id_valid = iv; h1.id_rs1 = a; h1.id_rs2 = b; h1.id_uses_rs2 = ub;
        h1.id_is_mc = m; h1.ex_memRead = ld; h1.ex_rd = d; h1.branch_taken = br;
        if (r) begin left4 = 0; left1 = 0; end
        #1;
        assert (!(br && left4 > 0 && !r)) else $fatal(1, "FAIL %s branch_taken driven in MC_BUSY", tag);
        o4 = {h4.pcWrite, h4.ifidWrite, h4.ifidFlush, h4.Flush_HD, h4.ex_hold, h4.mem_bubble, h4.busy_o};
        o1 = {h1.pcWrite, h1.ifidWrite, h1.ifidFlush, h1.Flush_HD, h1.ex_hold, h1.mem_bubble, h1.busy_o};
        e4 = expect_out(left4);
        e1 = expect_out(left1);
        n_cmp++;
        assert (o4 === e4) else begin n_err++; $error("FAIL %s lat4 observed=%b expected=%b", tag, o4, e4); end
        n_cmp++;
        assert (o1 === e1) else begin n_err++; $error("FAIL %s lat1 observed=%b expected=%b", tag, o1, e1); end
        @(negedge clk);
        left4 = next_left(left4, 4);
        left1 = next_left(left1, 1);
    endtask

    initial begin
        drive(1, 1, 5, 5, 1, 1, 1, 5, 1, "reset_forced");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "first_run");
        drive(0, 1, 5, 0, 0, 0, 1, 5, 0, "lu_rs1_stall");
        drive(0, 1, 5, 0, 0, 0, 0, 5, 0, "lu_next_normal");
        drive(0, 1, 0, 0, 0, 0, 1, 0, 0, "lu_rd_zero");
        drive(0, 1, 1, 5, 0, 0, 1, 5, 0, "rs2_unused");
        drive(0, 1, 1, 5, 1, 0, 1, 5, 0, "lu_rs2_stall");
        drive(0, 0, 5, 5, 1, 0, 1, 5, 0, "lu_id_invalid");
        drive(0, 1, 5, 0, 0, 0, 1, 5, 1, "branch_over_lu");
        drive(0, 1, 2, 3, 1, 1, 0, 0, 0, "mc_enter");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "mc_busy1");
        drive(0, 1, 5, 0, 0, 0, 1, 5, 0, "mc_busy2_ignore_lu");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "mc_busy3");
        drive(0, 1, 2, 3, 1, 1, 0, 0, 0, "mc_final_run_b2b");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "b2b_busy1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "b2b_busy2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "b2b_busy3");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "b2b_done");
        drive(0, 1, 2, 3, 1, 1, 0, 0, 0, "mc_enter2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "mc2_busy1");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_mid_busy");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "after_rst_run");
        drive(0, 1, 2, 3, 1, 1, 0, 0, 1, "branch_blocks_mc");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "no_busy_after_br");
        drive(0, 1, 4, 0, 0, 1, 1, 4, 0, "lu_blocks_mc");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "no_busy_after_lu");
        for (int i = 0; i < 400; i++) begin
            logic r, br;
            r  = ($urandom_range(0, 39) == 0);
            br = (left4 == 0) && ($urandom_range(0, 5) == 0);
            drive(r, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
                  br, "random");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
